// File: rtl/float16_acc_if.sv
// Product stream into the float16 window accumulator and the summed result out.
// The multiplier side drives master; the accumulator takes slave.
interface float16_acc_if;
   logic        de_in;
   logic [15:0] data_in;
   logic        acc_clr;
   logic        de_out;
   logic [15:0] data_out;

   modport master (output de_in, data_in, acc_clr, input de_out, data_out);
   modport slave  (input de_in, data_in, acc_clr, output de_out, data_out);
endinterface

// File: rtl/float16_acc.sv
// Sums ACC_LEN float16 products exactly in a 48-bit fixed-point accumulator
// (LSB 2^-24), then normalises each window once, truncating to float16.
module float16_acc #(
   parameter int ACC_LEN = 9
) (
   input  logic          clk,
   input  logic          rst_b,
   float16_acc_if.slave  bus
);
   localparam logic [5:0] LAST = 6'(ACC_LEN - 1);

   logic                vld_p0;
   logic [15:0]         data_p0;
   logic                vld_p1;
   logic signed [47:0]  term_p1;
   logic [5:0]          cnt;
   logic signed [47:0]  acc;
   logic                vld_p2;
   logic                vld_p3;
   logic                sign_p3;
   logic [46:0]         mag_p3;
   logic                de_out_q;
   logic [15:0]         data_out_q;

   // exp==0 is zero regardless of sign/frac; no subnormals exist
   function automatic logic signed [47:0] to_term(input logic [15:0] h);
      logic [47:0] m;
      m = 48'({1'b1, h[9:0]}) << (h[14:10] - 5'd1);
      if (h[14:10] == 5'd0) m = '0;
      return h[15] ? -$signed(m) : $signed(m);
   endfunction

   // Leading-one normalise with flush-to-zero and saturation to the largest finite value
   function automatic logic [15:0] to_half(input logic s, input logic [46:0] m);
      logic [5:0]  p;
      logic [46:0] sh;
      p = '0;
      for (int i = 0; i < 47; i++) if (m[i]) p = 6'(i);
      sh = m << (6'd46 - p);
      if (p < 6'd10) return 16'h0000;
      if (p > 6'd40) return {s, 5'd31, 10'h3FF};
      return {s, 5'(p - 6'd9), sh[45:36]};
   endfunction

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         vld_p0     <= 1'b0;
         vld_p1     <= 1'b0;
         vld_p2     <= 1'b0;
         vld_p3     <= 1'b0;
         cnt        <= '0;
         acc        <= '0;
         de_out_q   <= 1'b0;
         data_out_q <= '0;
      end else begin
         // stage 0: input capture
         vld_p0 <= bus.de_in & ~bus.acc_clr;
         // stage 1: term convert
         vld_p1 <= vld_p0 & ~bus.acc_clr;
         // stage 2: accumulate; an abort drops every term not yet in acc
         vld_p2 <= vld_p1 & ~bus.acc_clr & (cnt == LAST);
         if (bus.acc_clr) begin
            cnt <= '0;
         end else if (vld_p1) begin
            acc <= (cnt == 6'd0) ? term_p1 : acc + term_p1;
            cnt <= (cnt == LAST) ? 6'd0 : cnt + 6'd1;
         end
         // stage 3: sign/magnitude
         vld_p3 <= vld_p2;
         // stage 4: normalise
         de_out_q   <= vld_p3;
         data_out_q <= vld_p3 ? to_half(sign_p3, mag_p3) : 16'h0000;
      end
   end

   always_ff @(posedge clk) begin
      data_p0 <= bus.data_in;
      term_p1 <= to_term(data_p0);
      // acc still holds the finished sum while the next window's first term lands
      if (vld_p2) begin
         sign_p3 <= acc[47];
         mag_p3  <= acc[47] ? 47'(-acc) : acc[46:0];
      end
   end

   assign bus.de_out   = de_out_q;
   assign bus.data_out = data_out_q;
endmodule

// File: tb/tb_float16_acc.sv
// Randomised and directed bench for float16_acc against an integer-sum window model.
module tb_float16_acc;
   localparam int ACC_LEN = 9;

   logic clk = 1'b0;
   logic rst_b = 1'b0;
   always #5 clk = ~clk;

   float16_acc_if bus ();
   float16_acc #(.ACC_LEN(ACC_LEN)) dut (.clk(clk), .rst_b(rst_b), .bus(bus));

   typedef struct { int due; logic [15:0] d; } exp_t;
   exp_t        exp_q[$];
   logic [15:0] od_q[$];
   int          oc_q[$];
   int          total = 0;
   int          bad = 0;
   int          cyc = 0;
   int          m_cnt = 0;
   longint      m_sum = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%h want=%h (cycle %0d)", tag, got, want, cyc);
      end
   endtask

   // value of a product in units of 2^-24
   function automatic longint h2units(input logic [15:0] h);
      longint v;
      if (h[14:10] == 5'd0) return 0;
      v = longint'(1024 + h[9:0]) * (longint'(1) << (h[14:10] - 1));
      return h[15] ? -v : v;
   endfunction

   function automatic logic [15:0] units2h(input longint s);
      logic   sg;
      longint a;
      int     e;
      sg = (s < 0);
      a  = sg ? -s : s;
      if (a < 1024) return 16'h0000;
      e = 1;
      while (a >= 2048) begin
         a = a >> 1;
         e++;
      end
      if (e > 31) return {sg, 15'h7FFF};
      return {sg, 5'(e), 10'(a - 1024)};
   endfunction

   task automatic step(input logic de, input logic [15:0] d, input logic clr);
      exp_t x;
      bus.de_in = de; bus.data_in = d; bus.acc_clr = clr;
      @(posedge clk); #1;
      if (clr) begin
         m_cnt = 0; m_sum = 0;
      end else if (de) begin
         m_sum += h2units(d);
         m_cnt++;
         if (m_cnt == ACC_LEN) begin
            x.due = cyc + 4; x.d = units2h(m_sum);
            exp_q.push_back(x);
            m_cnt = 0; m_sum = 0;
         end
      end
      bus.de_in = 1'b0; bus.acc_clr = 1'b0;
   endtask

   task automatic win(input logic [15:0] v);
      repeat (ACC_LEN) step(1'b1, v, 1'b0);
   endtask

   task automatic drain();
      repeat (8) step(1'b0, 16'h0000, 1'b0);
   endtask

   task automatic clr_outs();
      od_q.delete(); oc_q.delete();
   endtask

   task automatic outs_are(input string tag, input int n, input logic [15:0] w0,
                           input logic [15:0] w1, input logic [15:0] w2);
      logic [15:0] w[3];
      w[0] = w0; w[1] = w1; w[2] = w2;
      chk({tag, "_count"}, od_q.size(), n);
      for (int i = 0; i < n && i < od_q.size(); i++) chk(tag, od_q[i], w[i]);
   endtask

   always @(negedge clk) begin
      if (rst_b) begin
         if (bus.de_out) begin
            od_q.push_back(bus.data_out);
            oc_q.push_back(cyc);
         end
         if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            chk("de_out", bus.de_out, 1);
            chk("data_out", bus.data_out, exp_q[0].d);
            void'(exp_q.pop_front());
         end else begin
            chk("idle_de_out", bus.de_out, 0);
            chk("idle_data_out", bus.data_out, 0);
         end
      end
   end

   initial begin
      logic [15:0] mix[9];
      logic [15:0] t;
      int          lc;
      int          base;
      bus.de_in = 1'b0; bus.data_in = 16'h0000; bus.acc_clr = 1'b0;
      #12;
      chk("reset_de_out", bus.de_out, 0);
      chk("reset_data_out", bus.data_out, 0);
      @(negedge clk) rst_b = 1'b1;

      clr_outs(); win(16'h3C00); lc = cyc; drain();
      outs_are("basic", 1, 16'h4880, 0, 0);
      if (oc_q.size() > 0) chk("latency", oc_q[0] - lc, 4);

      for (int i = 0; i < 9; i++) mix[i] = (i < 4) ? 16'h4000 : 16'hBC00;
      for (int i = 8; i > 0; i--) begin
         int j = $urandom_range(0, i);
         t = mix[i]; mix[i] = mix[j]; mix[j] = t;
      end
      clr_outs();
      for (int i = 0; i < 9; i++) begin
         repeat ($urandom_range(0, 2)) step(1'b0, 16'h0000, 1'b0);
         step(1'b1, mix[i], 1'b0);
      end
      drain();
      outs_are("mixed_gaps", 1, 16'h4200, 0, 0);

      clr_outs();
      step(1'b1, 16'h3C00, 1'b0); step(1'b1, 16'hBC00, 1'b0);
      repeat (7) step(1'b1, 16'h03FF, 1'b0);
      step(1'b1, 16'h0401, 1'b0); step(1'b1, 16'h8400, 1'b0);
      repeat (7) step(1'b1, 16'h0000, 1'b0);
      drain();
      outs_are("zero_underflow", 2, 16'h0000, 16'h0000, 0);

      clr_outs();
      win(16'h7FFF); win(16'hFFFF); win(16'h7800); drain();
      outs_are("saturate", 3, 16'h7FFF, 16'hFFFF, 16'h7FFF);

      clr_outs();
      repeat (5) step(1'b1, 16'h3C00, 1'b0);
      step(1'b1, 16'h3C00, 1'b1);
      win(16'h3C00); drain();
      outs_are("abort", 1, 16'h4880, 0, 0);

      clr_outs();
      repeat (4) step(1'b1, 16'h3C00, 1'b0);
      rst_b = 1'b0;
      #1 chk("async_reset_de_out", bus.de_out, 0);
      repeat (2) @(posedge clk);
      @(negedge clk) rst_b = 1'b1;
      m_cnt = 0; m_sum = 0; exp_q.delete();
      drain();
      outs_are("reset_lost", 0, 0, 0, 0);
      win(16'h3C00); drain();
      outs_are("after_reset", 1, 16'h4880, 0, 0);

      clr_outs();
      win(16'h3C00); win(16'h4000); win(16'hBC00); drain();
      outs_are("stream", 3, 16'h4880, 16'h4C80, 16'hC880);
      if (oc_q.size() == 3) begin
         chk("stream_gap1", oc_q[1] - oc_q[0], 9);
         chk("stream_gap2", oc_q[2] - oc_q[1], 9);
      end

      for (int w = 0; w < 25; w++) begin
         base = $urandom_range(1, 28);
         for (int k = 0; k < ACC_LEN; k++) begin
            if (w % 3 != 0) repeat ($urandom_range(0, 2)) step(1'b0, 16'h0000, 1'b0);
            t = 16'($urandom);
            t[14:10] = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'(base + $urandom_range(0, 3));
            step(1'b1, t, 1'b0);
         end
      end
      drain();
      chk("pending_expected", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/float16_acc.md
# float16_acc

Accumulates a fixed-length window of float16 products (sign 1, exp 5, frac 10) into one float16 sum. In the convolution datapath it sits directly downstream of the float16 multiplier. Each product is aligned into a wide signed fixed-point accumulator, so there is no rounding error inside the window. At the end of each window the sum is normalised once and emitted as float16. The block accepts one product per clock with no back-pressure.

## Interface
- ACC_LEN, 9: number of products per output window (3x3 kernel); legal range 1..64.
- clk  input  1  clock, rising edge.
- rst_b  input  1  reset; asynchronous assertion, active-low.
- de_in  input  1  product valid, one term per high cycle; gaps allowed.
- data_in  input  16  float16 product.
- acc_clr  input  1  synchronous abort of the current window.
- de_out  output  1  result valid, single-cycle pulse; reset 0.
- data_out  output  16  float16 sum; 0x0000 whenever de_out is low; reset 0x0000.

## Operation
- Number format matches the multiplier:
  - exp==0 means zero, whatever the sign or frac bits; there are no subnormals.
  - exp 1..31 are all normal values; exp 31 is the largest finite exponent, not inf or NaN.
- Stage 1 (term convert), registered:
  - magnitude = {1,frac} << (exp-1), LSB weight 2^-24, 41 bits max.
  - The magnitude is negated if sign=1, giving a 48-bit two's-complement term.
  - The term is 0 when exp==0.
- Stage 2 (accumulate):
  - 48-bit signed accumulator `acc` and a 6-bit term counter `cnt`.
  - On a valid term: if cnt==0 then acc<=term, else acc<=acc+term.
  - If cnt==ACC_LEN-1, cnt<=0 and the window-done flag is set for one cycle; otherwise cnt<=cnt+1.
  - 48 bits cannot overflow for 64 max-magnitude terms.
- Stage 3 (sign/magnitude), registered: sign=acc[47]; mag=|acc|, 47 bits.
- Stage 4 (normalise), registered into data_out:
  - mag==0 gives 0x0000.
  - Otherwise, with p = index of the leading one in mag, E = p-9.
  - E<1 (underflow): flush to 0x0000.
  - E>31 (overflow): saturate to {sign,5'd31,10'd1023}.
  - Otherwise the output is {sign, E[4:0], mag[p-1:p-10]}. Low bits are truncated; there is no rounding.
- Windows run back-to-back with no bubble; the first term of the next window may arrive the cycle after the last term of the previous one.
- acc_clr:
  - Sets cnt<=0 and discards any term in stage 1.
  - The de_in term sampled in the same cycle is discarded (acc_clr wins).
  - A window whose done flag is already set, or is already past stage 2, still completes and emits.
- Asynchronous reset clears all pipeline valids, cnt, acc and the outputs. A partial window is lost with no output.

## Timing
- Latency: de_out rises on the 4th rising edge after the edge that sampled the window's last de_in.
- Throughput: 1 term/clock. With continuous de_in, de_out pulses every ACC_LEN clocks.
- Idle cycles (de_in=0) do not advance cnt or change acc.
- ACC_LEN=1: every valid input produces one output, which is the input value unchanged. The one exception is exp==0 inputs, which produce 0x0000.

## Test plan
- Basic sum, ACC_LEN=9:
  - Stimulus: nine consecutive 0x3C00 (1.0).
  - Required: exactly one de_out, 4 clocks after the last input, data_out=0x4880 (9.0).
- Mixed signs with gaps:
  - Stimulus: four 0x4000 (2.0) and five 0xBC00 (-1.0), interleaved with random de_in=0 cycles.
  - Required: data_out=0x4200 (3.0).
- Zero handling:
  - Stimulus: window 0x3C00, 0xBC00, then seven 0x03FF (exp 0).
  - Required: 0x0000.
  - Stimulus: window 0x0401, 0x8400, then seven 0x0000 (sum is 2^-24, which underflows).
  - Required: 0x0000.
- Saturation:
  - Stimulus: nine 0x7FFF. Required: 0x7FFF.
  - Stimulus: nine 0xFFFF. Required: 0xFFFF.
  - Stimulus: nine 0x7800 (exp 30). Required: 0x7FFF.
- Abort and reset:
  - Stimulus: five 0x3C00, then acc_clr together with a 0x3C00, then nine 0x3C00.
  - Required: a single de_out with 0x4880.
  - Stimulus: assert rst_b low mid-window.
  - Required: no de_out, and the next full window is correct.
- Streaming:
  - Stimulus: 3 back-to-back windows of 1.0, 2.0 and -1.0 (9 terms each, continuous de_in).
  - Required: de_out pulses exactly 9 clocks apart carrying 0x4880, 0x4C80, 0xC880.
